// File: rtl/reaction_sequencer.sv
// rtl/reaction_sequencer.sv - reaction-time game sequencer: random delay, GO prompt, ms timing, best score
module reaction_sequencer #(
    parameter int TICKS_PER_MS     = 50000,
    parameter int MIN_DELAY_MS     = 1000,
    parameter int DELAY_RANGE_BITS = 11,
    parameter int MAX_MS           = 9999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        show_best,
    output logic        led_go,
    output logic        bcd_run,
    output logic        bcd_clear,
    output logic        ms_tick,
    output logic        done,
    output logic        false_start,
    output logic        timeout,
    output logic [13:0] reaction_ms,
    output logic [13:0] best_ms,
    output logic        best_valid,
    output logic [13:0] display_ms,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_GO    = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DW = 17;
    // Selects the low DELAY_RANGE_BITS of the LFSR; all-zero mask gives a fixed delay.
    localparam logic [10:0] RAND_MASK = 11'((32'd1 << DELAY_RANGE_BITS) - 32'd1);

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic [13:0]     reaction_q, reaction_d;
    logic [13:0]     best_q, best_d;
    logic            best_valid_q, best_valid_d;
    logic            led_go_q, led_go_d;
    logic            bcd_run_q, bcd_run_d;
    logic            bcd_clear_q, bcd_clear_d;
    logic            ms_tick_q, ms_tick_d;
    logic            done_q, done_d;
    logic            false_start_q, false_start_d;
    logic            timeout_q, timeout_d;
    logic            tick;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        tick          = (presc_q == PW'(TICKS_PER_MS - 1));
        state_d       = state_q;
        delay_d       = delay_q;
        reaction_d    = reaction_q;
        best_d        = best_q;
        best_valid_d  = best_valid_q;
        timeout_d     = timeout_q;
        bcd_clear_d   = 1'b0;
        ms_tick_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                // A simultaneous stop wins, so start only acts alone.
                if (start && !stop) begin
                    delay_d     = DW'(MIN_DELAY_MS) + DW'(lfsr_q[10:0] & RAND_MASK);
                    reaction_d  = '0;
                    timeout_d   = 1'b0;
                    bcd_clear_d = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_FAULT;
                end else if (tick) begin
                    if (delay_q <= DW'(1)) begin
                        delay_d = '0;
                        state_d = S_GO;
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end
            S_GO: begin
                // Stop beats a coincident tick: the count freezes without that tick.
                if (stop) begin
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                    if (!best_valid_q || (reaction_q < best_q)) begin
                        best_d       = reaction_q;
                        best_valid_d = 1'b1;
                    end
                end else if (tick) begin
                    reaction_d = reaction_q + 14'd1;
                    ms_tick_d  = 1'b1;
                    if (reaction_d >= 14'(MAX_MS)) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The prescaler realigns on entry to WAIT/GO so the first tick lands a full ms later.
        if ((state_d != state_q) && ((state_d == S_WAIT) || (state_d == S_GO))) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        led_go_d      = (state_d == S_GO);
        bcd_run_d     = (state_d == S_GO);
        done_d        = (state_d == S_DONE);
        false_start_d = (state_d == S_FAULT);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lfsr_q        <= 16'hACE1;
            presc_q       <= '0;
            delay_q       <= '0;
            reaction_q    <= '0;
            best_q        <= '0;
            best_valid_q  <= 1'b0;
            led_go_q      <= 1'b0;
            bcd_run_q     <= 1'b0;
            bcd_clear_q   <= 1'b0;
            ms_tick_q     <= 1'b0;
            done_q        <= 1'b0;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            presc_q       <= presc_d;
            delay_q       <= delay_d;
            reaction_q    <= reaction_d;
            best_q        <= best_d;
            best_valid_q  <= best_valid_d;
            led_go_q      <= led_go_d;
            bcd_run_q     <= bcd_run_d;
            bcd_clear_q   <= bcd_clear_d;
            ms_tick_q     <= ms_tick_d;
            done_q        <= done_d;
            false_start_q <= false_start_d;
            timeout_q     <= timeout_d;
        end
    end

    assign state       = state_q;
    assign led_go      = led_go_q;
    assign bcd_run     = bcd_run_q;
    assign bcd_clear   = bcd_clear_q;
    assign ms_tick     = ms_tick_q;
    assign done        = done_q;
    assign false_start = false_start_q;
    assign timeout     = timeout_q;
    assign reaction_ms = reaction_q;
    assign best_ms     = best_q;
    assign best_valid  = best_valid_q;
    assign display_ms  = show_best ? best_q : reaction_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// tb/tb_reaction_sequencer.sv - self-checking bench for reaction_sequencer
module tb_reaction_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic        show_best;
    logic        led_go;
    logic        bcd_run;
    logic        bcd_clear;
    logic        ms_tick;
    logic        done;
    logic        false_start;
    logic        timeout;
    logic [13:0] reaction_ms;
    logic [13:0] best_ms;
    logic        best_valid;
    logic [13:0] display_ms;
    logic [2:0]  state;

    reaction_sequencer #(
        .TICKS_PER_MS(4),
        .MIN_DELAY_MS(2),
        .DELAY_RANGE_BITS(0),
        .MAX_MS(20)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .stop(stop),
        .show_best(show_best),
        .led_go(led_go),
        .bcd_run(bcd_run),
        .bcd_clear(bcd_clear),
        .ms_tick(ms_tick),
        .done(done),
        .false_start(false_start),
        .timeout(timeout),
        .reaction_ms(reaction_ms),
        .best_ms(best_ms),
        .best_valid(best_valid),
        .display_ms(display_ms),
        .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // mode: 0 = stop after k ms, 1 = false start in WAIT, 2 = timeout
    typedef struct {
        int mode;
        int k;
        int exp_state;
        int exp_react;
        int exp_best;
        int exp_bv;
        int exp_to;
        int exp_ticks;
    } round_t;

    int checks = 0;
    int errors = 0;
    int tick_cnt;
    int clr_cnt;
    int led_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and accumulate pulse observations.
    task automatic cycle();
        @(negedge clock);
        if (ms_tick) tick_cnt++;
        if (bcd_clear) clr_cnt++;
        if (led_go) led_seen = 1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " state"}, int'(state), 0);
        chk({tag, " 1bit outputs"},
            int'({led_go, bcd_run, bcd_clear, ms_tick, done, false_start, timeout, best_valid}), 0);
        chk({tag, " reaction_ms"}, int'(reaction_ms), 0);
        chk({tag, " best_ms"}, int'(best_ms), 0);
    endtask

    task automatic run_round(input round_t r, input string tag);
        int n;
        tick_cnt = 0;
        clr_cnt  = 0;
        led_seen = 0;
        n = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk({tag, " enter WAIT"}, int'(state), 1);
        if (r.mode == 1) begin
            repeat (3) cycle();
            stop = 1'b1;
            cycle();
            stop = 1'b0;
        end else begin
            while (state == 3'd1 && n < 100) begin
                cycle();
                n++;
            end
            chk({tag, " WAIT cycles"}, n, 8);
            n = 0;
            if (r.mode == 0) begin
                while (tick_cnt < r.k && n < 1000) begin
                    cycle();
                    n++;
                end
                stop = 1'b1;
                cycle();
                stop = 1'b0;
            end else begin
                while (state == 3'd2 && n < 1000) begin
                    cycle();
                    n++;
                end
            end
        end
        chk({tag, " state"}, int'(state), r.exp_state);
        chk({tag, " reaction_ms"}, int'(reaction_ms), r.exp_react);
        chk({tag, " best_ms"}, int'(best_ms), r.exp_best);
        chk({tag, " best_valid"}, int'(best_valid), r.exp_bv);
        chk({tag, " done"}, int'(done), (r.exp_state == 3) ? 1 : 0);
        chk({tag, " false_start"}, int'(false_start), (r.exp_state == 4) ? 1 : 0);
        chk({tag, " timeout"}, int'(timeout), r.exp_to);
        chk({tag, " ms_tick count"}, tick_cnt, r.exp_ticks);
        chk({tag, " bcd_clear count"}, clr_cnt, 1);
        chk({tag, " led_go seen"}, led_seen, (r.mode == 1) ? 0 : 1);
        chk({tag, " led_go/bcd_run off"}, int'({led_go, bcd_run}), 0);
    endtask

    round_t rounds[6];
    round_t after_reset;

    initial begin
        int n;
        rounds[0] = '{0, 8, 3, 8, 8, 1, 0, 8};
        rounds[1] = '{1, 0, 4, 0, 8, 1, 0, 0};
        rounds[2] = '{2, 0, 3, 20, 8, 1, 1, 20};
        rounds[3] = '{0, 5, 3, 5, 5, 1, 0, 5};
        rounds[4] = '{0, 5, 3, 5, 5, 1, 0, 5};
        rounds[5] = '{0, 9, 3, 9, 5, 1, 0, 9};
        after_reset = '{0, 8, 3, 8, 8, 1, 0, 8};

        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        show_best = 1'b0;
        tick_cnt = 0;
        clr_cnt = 0;
        led_seen = 0;
        repeat (2) cycle();
        chk_reset_values("reset");
        reset = 1'b0;
        repeat (3) cycle();
        chk("idle no pulses", tick_cnt + clr_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            run_round(rounds[i], $sformatf("round%0d", i));
        end

        show_best = 1'b1;
        #1;
        chk("display best", int'(display_ms), 5);
        show_best = 1'b0;
        #1;
        chk("display reaction", int'(display_ms), 9);

        // Stop sampled on the same edge as the 4th GO tick.
        tick_cnt = 0;
        n = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        while (tick_cnt < 3 && n < 1000) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("coincide ms_tick", int'(ms_tick), 0);
        chk("coincide reaction_ms", int'(reaction_ms), 3);
        chk("coincide state", int'(state), 3);
        chk("coincide best_ms", int'(best_ms), 3);

        // Asynchronous reset in the middle of GO.
        tick_cnt = 0;
        n = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        while (tick_cnt < 2 && n < 1000) begin
            cycle();
            n++;
        end
        chk("midgo in GO", int'(state), 2);
        reset = 1'b1;
        #1;
        chk_reset_values("midgo reset");
        cycle();
        reset = 1'b0;
        tick_cnt = 0;
        clr_cnt = 0;
        repeat (5) cycle();
        chk("post reset no pulses", tick_cnt + clr_cnt, 0);
        chk("post reset state", int'(state), 0);
        run_round(after_reset, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
